// File: rtl/mc_mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory responder.
// Holds the FSM state encoding and the word geometry used by the RTL.
package mc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_LATENCY     = 2;
    localparam int NUM_LANES       = 4;
    localparam int WORD_W          = 32;

endpackage

// File: rtl/mc_mem_responder_if.sv
// Request/response handshake bundle between an initiator and the memory responder.
// The master modport is the initiator side; the slave modport is the responder side.
import mc_mem_pkg::*;

interface mc_mem_responder_if;
    logic                 req_valid;
    logic                 req_write;
    logic [31:0]          req_addr;
    logic [WORD_W-1:0]    req_wdata;
    logic [NUM_LANES-1:0] req_wstrb;
    logic                 req_ready;
    logic                 rsp_valid;
    logic [WORD_W-1:0]    rsp_rdata;
    logic                 rsp_err;
    logic                 rsp_ready;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mc_mem_array.sv
// Single-port synchronous RAM, per-byte write enables, registered read data.
// Read data updates only on an enabled load, so it holds steady between accesses.
import mc_mem_pkg::*;

module mc_mem_array #(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [WORD_W-1:0]    wdata,
    input  logic [NUM_LANES-1:0] wstrb,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en && we) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (wstrb[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mc_mem_responder.sv
// Non-pipelined memory responder: accept, wait LATENCY cycles, respond, hold until consumed.
// MC_MEM_ALIGN_CHECK_EN: when defined, misaligned addresses return rsp_err without touching memory.
import mc_mem_pkg::*;

module mc_mem_responder #(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic                clk,
    input  logic                reset,
    mc_mem_responder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t               state_d, state_q;
    logic [3:0]           cnt_d, cnt_q;
    logic                 write_d, write_q;
    logic                 err_d, err_q;
    logic [AW-1:0]        idx_d, idx_q;
    logic [WORD_W-1:0]    wdata_d, wdata_q;
    logic [NUM_LANES-1:0] wstrb_d, wstrb_q;

    logic                 ram_en, ram_we;
    logic [AW-1:0]        ram_idx;
    logic [WORD_W-1:0]    ram_wdata, ram_rdata;
    logic [NUM_LANES-1:0] ram_wstrb;
    logic                 req_err;
    logic                 unused_addr_bits;

`ifdef MC_MEM_ALIGN_CHECK_EN
    assign req_err = (bus.req_addr[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    // Upper address bits wrap away; low bits only matter with the alignment check.
    assign unused_addr_bits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        err_d     = err_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        ram_en    = 1'b0;
        ram_we    = write_q;
        ram_idx   = idx_q;
        ram_wdata = wdata_q;
        ram_wstrb = wstrb_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    err_d   = req_err;
                    idx_d   = bus.req_addr[AW+1:2];
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    if (LATENCY == 0) begin
                        // Zero wait: the array is driven straight from the request.
                        state_d   = RESP;
                        ram_en    = !req_err;
                        ram_we    = bus.req_write;
                        ram_idx   = bus.req_addr[AW+1:2];
                        ram_wdata = bus.req_wdata;
                        ram_wstrb = bus.req_wstrb;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    ram_en  = !err_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    mc_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (ram_wdata),
        .wstrb (ram_wstrb),
        .rdata (ram_rdata)
    );

    // Outputs are gated by state so reset clears them without resetting the RAM.
    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = (state_q == RESP && !write_q && !err_q) ? ram_rdata : '0;
`ifdef MC_MEM_ALIGN_CHECK_EN
    assign bus.rsp_err   = (state_q == RESP) && err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mc_mem_responder.sv
// Bench for mc_mem_responder: main instance at LATENCY=2 checked cycle-by-cycle against a
// word-array model; a second instance at LATENCY=4 exercises reset during WAIT.
module tb_mc_mem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst2 = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   cmp_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mc_mem_responder_if bus ();
    mc_mem_responder_if bus2 ();

    mc_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mc_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2)
    );

    typedef struct {
        int          acc;
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mmem [256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Model: sequential word array; a response is due LATENCY+1 cycles after the accept cycle.
    task automatic model_push(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int acc);
        exp_t e;
        logic [7:0] idx;
        idx     = a[9:2];
        e.acc   = acc;
        e.due   = acc + LAT + 1;
        e.rdata = 32'h0;
        e.err   = 1'b0;
`ifdef MC_MEM_ALIGN_CHECK_EN
        e.err = (a[1:0] != 2'b00);
`endif
        if (!e.err) begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mmem[idx][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                e.rdata = mmem[idx];
            end
        end
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        wait (cmp_on);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("idle_rsp_valid", bus.rsp_valid, 1'b0);
                chk("idle_req_ready", bus.req_ready, 1'b1);
            end else begin
                e = exp_q[0];
                if (cyc == e.acc) begin
                    chk("acc_req_ready", bus.req_ready, 1'b1);
                    chk("acc_rsp_valid", bus.rsp_valid, 1'b0);
                end else if (cyc < e.due) begin
                    chk("wait_req_ready", bus.req_ready, 1'b0);
                    chk("wait_rsp_valid", bus.rsp_valid, 1'b0);
                end else begin
                    chk("resp_rsp_valid", bus.rsp_valid, 1'b1);
                    chk("resp_req_ready", bus.req_ready, 1'b0);
                    chk("resp_rdata", bus.rsp_rdata, e.rdata);
                    chk("resp_err", bus.rsp_err, e.err);
                    if (bus.rsp_valid && bus.rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One transaction on the main instance. keep_valid leaves a second request asserted
    // through WAIT/RESP, which must not be captured.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int hold, input bit keep_valid,
                       output logic [31:0] rd, output logic er, output int lat);
        int t;
        int acc;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        @(negedge clk);
        t = 0;
        while (!bus.req_ready && t < 100) begin @(negedge clk); t++; end
        chk("req_ready_timeout", 32'(t < 100), 32'd1);
        acc = cyc;
        model_push(w, a, d, s, acc);
        @(posedge clk); #1;
        if (keep_valid) begin
            bus.req_write = 1'b1;
            bus.req_addr  = 32'h50;
            bus.req_wdata = 32'h99;
            bus.req_wstrb = 4'hF;
        end else begin
            bus.req_valid = 1'b0;
        end
        @(negedge clk);
        t = 0;
        while (!bus.rsp_valid && t < 100) begin @(negedge clk); t++; end
        chk("rsp_valid_timeout", 32'(t < 100), 32'd1);
        lat = cyc - acc;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        repeat (hold) @(negedge clk);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic txn2(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
        int t;
        int acc;
        @(posedge clk); #1;
        bus2.req_valid = 1'b1;
        bus2.req_write = w;
        bus2.req_addr  = a;
        bus2.req_wdata = d;
        bus2.req_wstrb = 4'hF;
        @(negedge clk);
        t = 0;
        while (!bus2.req_ready && t < 100) begin @(negedge clk); t++; end
        chk("t2_ready_timeout", 32'(t < 100), 32'd1);
        acc = cyc;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        @(negedge clk);
        t = 0;
        while (!bus2.rsp_valid && t < 100) begin @(negedge clk); t++; end
        chk("t2_rsp_timeout", 32'(t < 100), 32'd1);
        lat = cyc - acc;
        rd  = bus2.rsp_rdata;
        @(posedge clk); #1;
        bus2.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus2.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = '0;
        bus.req_wdata  = '0;   bus.req_wstrb  = '0;   bus.rsp_ready = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0;
        bus2.req_wdata = '0;   bus2.req_wstrb = '0;   bus2.rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) mmem[i] = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        rst2  = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", bus.req_ready, 1'b1);
        cmp_on = 1'b1;

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, er, lat);
        chk("store_latency", 32'(lat), 32'd3);
        chk("store_rdata_zero", rd, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("load_latency", 32'(lat), 32'd3);
        chk("load_deadbeef", rd, 32'hDEADBEEF);

        txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, rd, er, lat);
        txn(1'b1, 32'h20, 32'h000000AA, 4'h1, 0, 1'b0, rd, er, lat);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("byte_strobe", rd, 32'h112233AA);

        txn(1'b0, 32'h20, 32'h0, 4'h0, 5, 1'b1, rd, er, lat);
        chk("backpressure_rdata", rd, 32'h112233AA);

        txn(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0, 1'b0, rd, er, lat);
        txn(1'b0, 32'h000, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("wrap_rdata", rd, 32'hCAFEF00D);

        txn(1'b1, 32'h10, 32'h01020304, 4'h0, 0, 1'b0, rd, er, lat);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("wstrb0_unchanged", rd, 32'hDEADBEEF);

        txn(1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
`ifdef MC_MEM_ALIGN_CHECK_EN
        chk("misalign_err", er, 1'b1);
        chk("misalign_rdata", rd, 32'h0);
`else
        chk("misalign_err", er, 1'b0);
        chk("misalign_rdata", rd, 32'hDEADBEEF);
`endif

        for (int i = 0; i < 6; i++) begin
            txn(1'b1, 32'h80 + 32'(i*4), 32'hA5A5_0000 + 32'(i*32'h0101_0101), 4'hF, 0, 1'b0, rd, er, lat);
            txn(1'b1, 32'h80 + 32'(i*4), 32'h5A5A_5A5A, 4'(1 << (i % 4)), 0, 1'b0, rd, er, lat);
            txn(1'b0, 32'h80 + 32'(i*4), 32'h0, 4'h0, i % 3, 1'b0, rd, er, lat);
        end

        // Reset during WAIT on the LATENCY=4 instance discards the pending store.
        txn2(1'b1, 32'h30, 32'h12345678, rd, lat);
        chk("t2_latency", 32'(lat), 32'd5);
        @(posedge clk); #1;
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b1;
        bus2.req_addr  = 32'h30;
        bus2.req_wdata = 32'h55;
        @(negedge clk);
        chk("t2_store_ready", bus2.req_ready, 1'b1);
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        @(posedge clk); #1;
        rst2 = 1'b1;
        @(negedge clk);
        chk("t2_rst_rsp_valid", bus2.rsp_valid, 1'b0);
        chk("t2_rst_req_ready", bus2.req_ready, 1'b0);
        @(posedge clk); #1;
        rst2 = 1'b0;
        @(negedge clk);
        chk("t2_idle_req_ready", bus2.req_ready, 1'b1);
        chk("t2_idle_rsp_valid", bus2.rsp_valid, 1'b0);
        txn2(1'b0, 32'h30, 32'h0, rd, lat);
        chk("t2_prior_contents", rd, 32'h12345678);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_mem_responder.md
MC_MEM_RESPONDER -- requirements
Module: mc_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, gives the unified instruction/data memory size in 32-bit words (power of two, 16..4096).
REQ-002 Parameter LATENCY, default 2, gives the wait cycles between request accept and response (0..15).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_write  input  1  1 = store, 0 = load/fetch.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_wstrb  input  4  byte enables for a store; bit i enables byte lane i (little-endian).
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_rdata  output  32  load data; 0 for store responses.
REQ-013 rsp_err  output  1  response reports an access error.
REQ-014 rsp_ready  input  1  initiator consumes the response.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-017 A request SHALL be accepted on an edge where req_valid and req_ready are both 1; addr, write, wdata and wstrb are captured at that edge.
REQ-018 On accept, the FSM SHALL move to WAIT with the counter loaded to LATENCY, or go directly to RESP when LATENCY = 0.
REQ-019 In WAIT, the counter SHALL decrement each cycle; on the edge where it reaches 1, the FSM SHALL go to RESP and perform the array access.
REQ-020 rsp_valid SHALL rise exactly LATENCY+1 cycles after the accept edge.
REQ-021 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so accesses wrap modulo DEPTH_WORDS*4.
REQ-022 A store SHALL write only the bytes enabled by wstrb; wstrb = 0 SHALL leave memory unchanged but still produce a response.
REQ-023 A load SHALL return the full word; rsp_rdata SHALL stay stable while rsp_valid = 1.
REQ-024 In RESP, rsp_valid SHALL be 1 until an edge with rsp_ready = 1; the FSM then SHALL return to IDLE, and req_ready SHALL be 1 on the following cycle.
REQ-025 Maximum throughput SHALL be one transaction per LATENCY+2 cycles; there is no pipelining.
REQ-026 A store followed by a load to the same word SHALL return the stored data; there is no stale-read hazard.
REQ-027 req_valid held high during WAIT or RESP SHALL be ignored and SHALL NOT be captured until IDLE.

Reset
REQ-028 Asserting reset SHALL force IDLE and clear the counter, rsp_valid, rsp_rdata and rsp_err to 0.
REQ-029 While reset is asserted, req_ready SHALL be 0; it SHALL be 1 in the first cycle after deassertion.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 A store accepted but not yet committed when reset asserts SHALL be discarded.

Configuration
REQ-032 Macro MC_MEM_ALIGN_CHECK_EN, when defined, SHALL treat any request with req_addr[1:0] != 0 as an error.
- Error response: same latency, no array access, rsp_rdata = 0, rsp_err = 1.
REQ-033 When MC_MEM_ALIGN_CHECK_EN is undefined, req_addr[1:0] SHALL be ignored and rsp_err SHALL be tied to 0.

Structure
REQ-034 Package mc_mem_pkg SHALL hold:
- state enum (IDLE/WAIT/RESP);
- default DEPTH_WORDS and LATENCY;
- constants for the byte-lane count (4) and the word width (32).
REQ-035 The storage SHALL be a sub-module mc_mem_array: a single-port synchronous RAM with per-byte write enables and registered read data; the FSM and handshake logic live in mc_mem_responder.

Verification
REQ-036 Store then load, LATENCY=2:
- store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; then load 0x10 -> rdata 0xDEADBEEF;
- each rsp_valid rises 3 cycles after its accept.
REQ-037 Byte strobe:
- store 0x11223344 to 0x20, then store 0x000000AA with wstrb 0x1 -> load 0x20 returns 0x112233AA.
REQ-038 Backpressure:
- hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout;
- accept completes the cycle rsp_ready = 1.
REQ-039 Wrap-around, DEPTH_WORDS=256:
- store 0xCAFEF00D to 0x400 -> load 0x000 returns 0xCAFEF00D.
REQ-040 Reset mid-op:
- store 0x55 to 0x30 at LATENCY=4; assert reset during WAIT -> rsp_valid = 0 and FSM in IDLE;
- load 0x30 returns the prior contents.
REQ-041 Alignment check, with MC_MEM_ALIGN_CHECK_EN defined:
- load 0x13 -> rsp_err = 1, rsp_rdata = 0;
- without the macro, the same load returns the word at 0x10 with rsp_err = 0.
